// File: rtl/bf_sweep_checker.sv
// Exhaustive equivalence checker: walks every N-bit input vector in ascending order
// and compares the two implementation responses, counting mismatches and keeping the first.
module bf_sweep_checker #(
  parameter int N = 4,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop_on_fail,
  output logic [N-1:0] vec,
  input  logic [M-1:0] fa,
  input  logic [M-1:0] fb,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         fail_valid
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // SWEEP | driving vec and comparing fa/fb each cycle
  // DONE  | results held until the next start
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [N-1:0] VEC_ONE  = N'(1);
  localparam logic [N-1:0] VEC_LAST = '1;
  localparam logic [N:0]   ERR_ONE  = (N+1)'(1);

  logic [1:0] state;
  logic       mode;
  logic       mismatch;
  logic       last_vec;

  // Case inequality so an X/Z on either response counts as a failure.
  assign mismatch = (fa !== fb);
  assign last_vec = (vec == VEC_LAST);

  assign busy = (state == SWEEP);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      vec        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SWEEP;
            mode       <= stop_on_fail;
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
          end
        end
        SWEEP: begin
          if (mismatch) begin
            err_count <= err_count + ERR_ONE;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (last_vec || (mode && mismatch)) begin
            state <= DONE;
          end else begin
            vec <= vec + VEC_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_sweep_checker.sv
// Scoreboard bench for bf_sweep_checker (N=4, M=1): stimulus pushes expected sweep
// results, a negedge monitor pops and compares them when done rises.
module tb_bf_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic [3:0] vec;
  logic       fa, fb;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] first_fail;

  int checks = 0;
  int errors = 0;
  int tmode  = 0;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ff;
    logic       fv;
    logic       ps;
    logic [3:0] last;
    int         cycles;
  } exp_t;

  exp_t q[$];

  bf_sweep_checker #(.N(4), .M(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .vec(vec), .fa(fa), .fb(fb), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // fa = b~c + a~c + cd with vec = {a,b,c,d}
  always_comb begin
    fa = (vec[2] & ~vec[1]) | (vec[3] & ~vec[1]) | (vec[1] & vec[0]);
    case (tmode)
      1:       fb = fa ^ (vec == 4'b1011);
      2:       fb = fa ^ ((vec == 4'b0011) || (vec == 4'b1000));
      3:       fb = ~fa;
      4:       fb = (vec == 4'b0101) ? 1'bx : fa;
      default: fb = fa;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: per-cycle vec stepping while busy, result compare when done rises.
  logic prev_busy = 1'b0, prev_done = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) begin
        if (!prev_busy) bcnt = 0;
        chk("vec_step", 32'(vec), 32'(bcnt));
        chk("pass_in_sweep", 32'(pass), 32'd0);
        bcnt++;
      end
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err_count",  32'(err_count),  32'(e.err));
          chk("first_fail", 32'(first_fail), 32'(e.ff));
          chk("fail_valid", 32'(fail_valid), 32'(e.fv));
          chk("pass",       32'(pass),       32'(e.ps));
          chk("held_vec",   32'(vec),        32'(e.last));
          chk("busy_cycles", 32'(bcnt),      32'(e.cycles));
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic push(input logic [4:0] err, input logic [3:0] ff, input logic fv,
                      input logic ps, input logic [3:0] last, input int cyc);
    exp_t e;
    e.err = err; e.ff = ff; e.fv = fv; e.ps = ps; e.last = last; e.cycles = cyc;
    q.push_back(e);
  endtask

  task automatic do_start(input logic sof);
    @(negedge clk);
    start = 1'b1;
    stop_on_fail = sof;
    @(negedge clk);
    start = 1'b0;
    stop_on_fail = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n = 0;
    while (vec != v && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (vec != v) begin
      checks++;
      errors++;
      $display("FAIL vec_timeout actual=%0h required=%0h", vec, v);
    end
  endtask

  initial begin
    #12;
    chk("rst_vec",  32'(vec), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    chk("rst_ff",   32'(first_fail), 32'd0);
    chk("rst_fv",   32'(fail_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // equivalent implementations
    tmode = 0; push(5'd0, 4'd0, 1'b0, 1'b1, 4'hF, 16);
    do_start(1'b0); wait_done();

    // single mismatch at 1011
    tmode = 1; push(5'd1, 4'hB, 1'b1, 1'b0, 4'hF, 16);
    do_start(1'b0); wait_done();

    // mismatches at 0011 and 1000, stop at first
    tmode = 2; push(5'd1, 4'h3, 1'b1, 1'b0, 4'h3, 4);
    do_start(1'b1); wait_done();

    // every vector fails: count reaches 16 without wrapping
    tmode = 3; push(5'b10000, 4'h0, 1'b1, 1'b0, 4'hF, 16);
    do_start(1'b0); wait_done();

    // X on fb at 0101 (fa = 1 there)
    tmode = 4; push(5'd1, 4'h5, 1'b1, 1'b0, 4'hF, 16);
    do_start(1'b0); wait_done();

    // async reset mid-sweep discards partial results
    tmode = 3; push(5'd0, 4'd0, 1'b0, 1'b0, 4'hF, 16);
    do_start(1'b0);
    wait_vec(4'h7);
    rst = 1'b1;
    #1;
    q.delete();
    chk("midrst_vec",  32'(vec), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err",  32'(err_count), 32'd0);
    chk("midrst_fv",   32'(fail_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tmode = 0; push(5'd0, 4'd0, 1'b0, 1'b1, 4'hF, 16);
    do_start(1'b0); wait_done();

    // start during sweep is ignored
    tmode = 1; push(5'd1, 4'hB, 1'b1, 1'b0, 4'hF, 16);
    do_start(1'b0);
    wait_vec(4'h4);
    start = 1'b1;
    stop_on_fail = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop_on_fail = 1'b0;
    wait_done();

    // restart from DONE clears results and begins at vec 0
    tmode = 0; push(5'd0, 4'd0, 1'b0, 1'b1, 4'hF, 16);
    do_start(1'b0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err",  32'(err_count), 32'd0);
    chk("restart_vec",  32'(vec), 32'd0);
    chk("restart_fv",   32'(fail_valid), 32'd0);
    wait_done();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf_sweep_checker.md
# bf_sweep_checker

Parametrised sequential equivalence checker for N-input, M-output boolean functions. It drives every input vector 0 to 2^N-1 in ascending order onto a shared bus that feeds two implementations of the same function (e.g. a gate-level and an assign-level version). Each cycle it compares their outputs, counts mismatches and captures the first failing vector. It is the reusable self-checking core for our boolean-function labs and replaces hand-written nested-loop testers.

## Interface
Parameters:
- N, default 4: input vector width (1..16).
- M, default 1: output width of each implementation under check (1..32).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured in IDLE or DONE only.
- stop_on_fail  input  1  sampled with start; 1 ends the sweep at the first mismatch.
- vec  output  N  current stimulus, registered. Bit N-1 is the MSB (first operand, e.g. a).
- fa  input  M  implementation A response, combinational from vec.
- fb  input  M  implementation B response, combinational from vec.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep end until the next accepted start or rst.
- pass  output  1  valid while done; 1 iff err_count == 0.
- err_count  output  N+1  number of mismatching vectors in the last or current sweep.
- first_fail  output  N  vec value of the first mismatch; valid when fail_valid = 1.
- fail_valid  output  1  set on the first mismatch of a sweep.

## Operation
- States: IDLE, SWEEP, DONE. Reset enters IDLE.
- IDLE or DONE with start = 1:
  - Go to SWEEP.
  - vec <= 0, err_count <= 0, fail_valid <= 0, first_fail <= 0, done <= 0.
  - Latch stop_on_fail into an internal mode bit.
- SWEEP, every cycle:
  - A mismatch is fa !== fb, i.e. any bit differs or either side is X/Z.
  - On a mismatch, err_count increments. If fail_valid = 0, then first_fail <= vec and fail_valid <= 1.
  - If vec == 2^N-1, or (mode = 1 and a mismatch occurred), go to DONE and hold vec. Otherwise vec <= vec + 1.
- DONE: busy = 0, done = 1, pass = (err_count == 0). All results hold.
- start while in SWEEP is ignored; it neither restarts nor extends the sweep.
- err_count is N+1 bits wide, so it holds 2^N without wrapping. vec never wraps past 2^N-1.
- pass is 0 outside DONE.

## Timing
- Reset values: vec = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, fail_valid = 0, state IDLE. rst acts immediately and asynchronously, including mid-sweep. Partial results are discarded.
- start sampled at edge k: busy = 1 and vec = 0 after edge k.
- Comparison for vec = v is sampled at the edge that ends the cycle in which vec = v. fa and fb must settle within one cycle.
- Full sweep: the comparison of 2^N-1 happens at edge k+2^N. After that edge, busy = 0 and done = 1. busy is high for exactly 2^N cycles.
- Early stop: a mismatch at vec = v ends the sweep at edge k+v+1. busy is high for v+1 cycles.
- err_count and fail_valid update at the same edge as the mismatching comparison.
- A mismatch on the final vector is counted and captured before DONE is entered.

## Test plan
- N=4, M=1, fa = fb = b~c + a~c + cd, stop_on_fail = 0. Required: vec steps 0..15, done 16 cycles after start, err_count = 16'd0, pass = 1, fail_valid = 0.
- Same setup but fb = fa ^ (vec == 4'b1011). Required: err_count = 1, first_fail = 4'b1011, fail_valid = 1, pass = 0, done after 16 cycles.
- fb differs at 0011 and 1000, stop_on_fail = 1. Required: done 4 cycles after start, vec held at 0011, err_count = 1, first_fail = 0011.
- fb = ~fa. Required: err_count = 5'b10000 (no wrap), first_fail = 0000. Also drive fb = 1'bx on vec 0101 with otherwise equal outputs: err_count = 1, first_fail = 0101.
- Assert rst while vec = 0111 mid-sweep. Required: all outputs return to reset values immediately. A following start performs a full 16-cycle sweep with clean counts.
- Pulse start at vec = 0100 mid-sweep. Required: ignored, with done still after 16 cycles. Pulse start again in DONE. Required: done drops, err_count clears, and a new sweep runs with vec = 0 at the next cycle.
